// File: rtl/fetch_sequencer.sv
// Multi-cycle Y86-64 fetch controller: byte-serial instruction fetch, bundle handoff over valid/ready.
// Optional FETCH_BRANCH_PREDICT_EN: jXX/call transfers continue fetch at valC instead of valP.
module fetch_sequencer #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_rvalid,
  input  logic              mem_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        icode,
  output logic [3:0]        ifun,
  output logic [3:0]        rA,
  output logic [3:0]        rB,
  output logic [63:0]       valC,
  output logic [ADDR_W-1:0] valP,
  output logic [2:0]        stat
);
  typedef enum logic [2:0] {FETCH_B0, FETCH_REG, FETCH_C, HOLD, HALTED} state_t;
  localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;

  function automatic logic has_reg(input logic [3:0] ic);
    return ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
  endfunction
  function automatic logic has_valc(input logic [3:0] ic);
    return ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
  endfunction
  function automatic logic [3:0] ins_len(input logic [3:0] ic);
    return 4'd1 + {3'b000, has_reg(ic)} + {has_valc(ic), 3'b000};
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, next_pc;
  logic [3:0]        byte_idx;
  logic [2:0]        k;
  logic              fetching, rd_ok, rd_err, xfer;
  logic [3:0]        b0_ic;

  assign fetching = (state_q == FETCH_B0) || (state_q == FETCH_REG) || (state_q == FETCH_C);
  // mem_err wins over mem_rvalid so a faulting byte is never captured
  assign rd_err   = fetching & mem_err;
  assign rd_ok    = fetching & mem_rvalid & ~mem_err;
  assign xfer     = (state_q == HOLD) & out_ready & ~pc_load;
  assign b0_ic    = mem_rdata[7:4];

  always_comb begin
    next_pc = valP;
`ifdef FETCH_BRANCH_PREDICT_EN
    if ((icode == 4'h7 || icode == 4'h8) && stat == AOK) next_pc = valC[ADDR_W-1:0];
`endif
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= FETCH_B0;
    else     state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_B0:
        if (rd_err) state_d = HOLD;
        else if (rd_ok) begin
          if (has_reg(b0_ic))       state_d = FETCH_REG;
          else if (has_valc(b0_ic)) state_d = FETCH_C;
          else                      state_d = HOLD;
        end
      FETCH_REG:
        if (rd_err)     state_d = HOLD;
        else if (rd_ok) state_d = has_valc(icode) ? FETCH_C : HOLD;
      FETCH_C:
        if (rd_err || (rd_ok && k == 3'd7)) state_d = HOLD;
      HOLD:
        if (xfer) state_d = (stat == AOK) ? FETCH_B0 : HALTED;
      default: state_d = state_q;
    endcase
    if (pc_load) state_d = FETCH_B0;
  end

  always_comb begin
    mem_rd_en = fetching & ~rst;
    mem_addr  = pc_q + ADDR_W'(byte_idx);
    out_valid = (state_q == HOLD);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc_q     <= RESET_PC;
      byte_idx <= '0;
      k        <= '0;
      icode    <= '0;
      ifun     <= '0;
      rA       <= 4'hF;
      rB       <= 4'hF;
      valC     <= '0;
      valP     <= RESET_PC;
      stat     <= AOK;
    end else if (pc_load) begin
      pc_q     <= pc_in;
      byte_idx <= '0;
      k        <= '0;
      rA       <= 4'hF;
      rB       <= 4'hF;
      valC     <= '0;
      stat     <= AOK;
    end else begin
      if (rd_err) stat <= ADR;
      else if (rd_ok) begin
        byte_idx <= byte_idx + 4'd1;
        case (state_q)
          FETCH_B0: begin
            icode <= b0_ic;
            ifun  <= mem_rdata[3:0];
            rA    <= 4'hF;
            rB    <= 4'hF;
            valC  <= '0;
            k     <= '0;
            valP  <= pc_q + ADDR_W'(ins_len(b0_ic));
            stat  <= (b0_ic > 4'hB) ? INS : (b0_ic == 4'h0) ? HLT : AOK;
          end
          FETCH_REG: begin
            rA <= mem_rdata[7:4];
            rB <= mem_rdata[3:0];
          end
          FETCH_C: begin
            valC[{k, 3'b000} +: 8] <= mem_rdata;
            k <= k + 3'd1;
          end
          default: ;
        endcase
      end
      if (xfer) begin
        pc_q     <= next_pc;
        byte_idx <= '0;
      end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer: byte memory with random wait states and faults,
// random backpressure and redirects, checked against an instruction-level fetch model.
module tb_fetch_sequencer;
  logic        clk = 1'b0, rst, pc_load, mem_rd_en, mem_rvalid, mem_err, out_valid, out_ready;
  logic [63:0] pc_in, mem_addr, valC, valP;
  logic [7:0]  mem_rdata;
  logic [3:0]  icode, ifun, rA, rB;
  logic [2:0]  stat;

  fetch_sequencer #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst(rst), .pc_load(pc_load), .pc_in(pc_in),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .mem_err(mem_err), .out_valid(out_valid),
    .out_ready(out_ready), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .valC(valC), .valP(valP), .stat(stat));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic [2:0]  stat;
    int          nbytes;
  } bundle_t;

  logic [7:0] mem [1024];
  bit         err_map [1024];
  int         checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // What fetch at pc must present: length from icode, bytes read in order, first fault truncates.
  function automatic bundle_t model(input logic [63:0] pc);
    bundle_t     b;
    int          len;
    bit          regs;
    logic [7:0]  by;
    logic [63:0] a;
    b.ra = 4'hF; b.rb = 4'hF; b.valc = '0; b.icode = '0; b.ifun = '0;
    b.valp = pc; b.stat = 3'd3; b.nbytes = 1;
    if (err_map[pc[9:0]]) return b;
    by = mem[pc[9:0]];
    b.icode = by[7:4]; b.ifun = by[3:0];
    case (b.icode)
      4'h2, 4'h6, 4'hA, 4'hB: len = 2;
      4'h7, 4'h8:             len = 9;
      4'h3, 4'h4, 4'h5:       len = 10;
      default:                len = 1;
    endcase
    regs     = (len == 2 || len == 10);
    b.valp   = pc + 64'(len);
    b.stat   = (b.icode > 4'hB) ? 3'd4 : (b.icode == 4'h0) ? 3'd2 : 3'd1;
    b.nbytes = len;
    for (int i = 1; i < len; i++) begin
      a = pc + 64'(i);
      if (err_map[a[9:0]]) begin
        b.stat = 3'd3; b.nbytes = i + 1;
        return b;
      end
      by = mem[a[9:0]];
      if (regs && i == 1) begin b.ra = by[7:4]; b.rb = by[3:0]; end
      else b.valc = b.valc | ({56'b0, by} << (8 * (i - (regs ? 2 : 1))));
    end
    return b;
  endfunction

  task automatic gen_prog();
    int a = 0, r;
    logic [3:0]  ic;
    logic [63:0] c;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 8'($urandom);
      err_map[i] = ($urandom_range(0, 149) == 0);
    end
    while (a < 1024) begin
      r = $urandom_range(0, 99);
      if (r < 3)      ic = 4'h0;
      else if (r < 5) ic = 4'($urandom_range(12, 15));
      else            ic = 4'($urandom_range(1, 11));
      mem[a & 1023] = {ic, 4'($urandom)};
      a++;
      if (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) begin
        mem[a & 1023] = 8'($urandom); a++;
      end
      if (ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8}) begin
        c = (ic == 4'h7 || ic == 4'h8) ? 64'($urandom_range(0, 1000)) : {$urandom, $urandom};
        for (int j = 0; j < 8; j++) begin mem[a & 1023] = c[8*j +: 8]; a++; end
      end
    end
  endtask

  bundle_t     cur;
  logic [63:0] exp_pc, nxt;
  int          cyc, start, rd_idx, halt_wait;
  bit          halted, zw, resp, load;

  initial begin
    rst = 1'b1; pc_load = 1'b0; pc_in = '0; mem_rvalid = 1'b0; mem_err = 1'b0;
    mem_rdata = '0; out_ready = 1'b0;
    gen_prog();
    repeat (2) @(negedge clk);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_icode", {ifun, icode}, 0);
    chk("rst_rA", rA, 4'hF);
    chk("rst_rB", rB, 4'hF);
    chk("rst_valC", valC, 0);
    chk("rst_valP", valP, 0);
    chk("rst_stat", stat, 1);
    rst = 1'b0;
    exp_pc = '0; cur = model(64'h0); rd_idx = 0; halted = 0; halt_wait = 0;
    start = 1; cyc = 0;
    while (cyc < 4000) begin
      @(negedge clk);
      cyc++;
      zw = (cyc < 400);
      resp = zw || ($urandom_range(0, 99) < 60);
      mem_rdata = 8'($urandom); mem_rvalid = 1'b0; mem_err = 1'b0;
      if (mem_rd_en && resp) begin
        if (err_map[mem_addr[9:0]]) mem_err = 1'b1;
        else begin mem_rvalid = 1'b1; mem_rdata = mem[mem_addr[9:0]]; end
      end
      out_ready = zw || ($urandom_range(0, 99) < 65);
      load = halted ? (halt_wait == 0) : (!zw && $urandom_range(0, 99) < 2);
      pc_load = load;
      if (load) begin
        pc_in = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7))
                                            : 64'($urandom_range(0, 1000));
        exp_pc = pc_in; cur = model(pc_in); rd_idx = 0; halted = 0; start = cyc + 1;
      end else if (halted) begin
        chk("halt_rd_en", mem_rd_en, 0);
        chk("halt_valid", out_valid, 0);
        halt_wait--;
      end else begin
        if (cyc - start > 300) begin chk("progress", 0, 1); break; end
        if (mem_rd_en) begin
          chk("addr", mem_addr, exp_pc + 64'(rd_idx));
          if (mem_rvalid || mem_err) rd_idx++;
        end
        if (out_valid) begin
          chk("stat", stat, cur.stat);
          if (cur.stat != 3'd3) begin
            chk("icode", icode, cur.icode);
            chk("ifun", ifun, cur.ifun);
            chk("valP", valP, cur.valp);
          end
          if (cur.stat == 3'd1) begin
            chk("rA", rA, cur.ra);
            chk("rB", rB, cur.rb);
            chk("valC", valC, cur.valc);
          end
          if (out_ready) begin
            chk("nbytes", rd_idx, cur.nbytes);
            if (zw) chk("latency", cyc - start, cur.nbytes);
            nxt = cur.valp;
`ifdef FETCH_BRANCH_PREDICT_EN
            if (cur.stat == 3'd1 && (cur.icode == 4'h7 || cur.icode == 4'h8)) nxt = cur.valc;
`endif
            if (cur.stat != 3'd1) begin
              halted = 1; halt_wait = $urandom_range(3, 25);
            end else begin
              exp_pc = nxt; cur = model(nxt); rd_idx = 0;
            end
            start = cyc + 1;
          end
        end
      end
    end
    pc_load = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_rd_en", mem_rd_en, 0);
    chk("arst_stat", stat, 1);
    chk("arst_valP", valP, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Multi-cycle Y86-64 fetch controller that drives the split/align datapath from a byte-wide instruction memory. It reads instruction bytes one per memory transaction and sizes each instruction from icode. It assembles icode/ifun/rA/rB/valC, computes valP, and hands the decoded fetch bundle to decode over a valid/ready handshake. It owns the fetch PC, accepts redirects, and stops on halt or fault.

Parameters:
ADDR_W, 64, fetch PC / memory address width
RESET_PC, 64'h0, PC loaded on reset

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
pc_load  input  1  redirect: abort current work, restart fetch at pc_in
pc_in  input  ADDR_W  redirect target
mem_rd_en  output  1  byte read request
mem_addr  output  ADDR_W  byte address
mem_rdata  input  8  read data, valid when mem_rd_en & mem_rvalid
mem_rvalid  input  1  read completes this cycle (may be combinational)
mem_err  input  1  address fault; qualified like mem_rvalid
out_valid  output  1  fetch bundle valid
out_ready  input  1  decode accepts bundle
icode  output  4  instruction code
ifun  output  4  function code
rA  output  4  byte1[7:4], else 4'hF
rB  output  4  byte1[3:0], else 4'hF
valC  output  64  little-endian constant, else 0
valP  output  ADDR_W  PC + instruction length
stat  output  3  1=AOK, 2=HLT, 3=ADR, 4=INS

Behaviour:
- Reset: pc=RESET_PC, state=FETCH_B0, mem_rd_en=0 during reset, out_valid=0, icode/ifun=0, rA=rB=4'hF, valC=0, valP=RESET_PC, stat=1.
- States: FETCH_B0, FETCH_REG, FETCH_C, HOLD, HALTED.
- Fetch states: mem_rd_en=1, mem_addr=pc+byte_idx. Each cycle holds until mem_rvalid=1, then byte captured and byte_idx increments.
- FETCH_B0 capture: icode=rdata[7:4], ifun=rdata[3:0].
- Lengths: 0,1,9 = 1 byte; 2,6,A,B = 2 bytes (regids); 7,8 = 9 bytes (valC only); 3,4,5 = 10 bytes (regids+valC). icode>4'hB = 1 byte, stat=INS.
- Next state from FETCH_B0: FETCH_REG if regids needed, else FETCH_C if valC needed, else HOLD.
- FETCH_REG captures rA/rB, then goes to FETCH_C or HOLD.
- FETCH_C: 3-bit counter k=0..7; byte k goes to valC[8k+7:8k]; after k=7 go to HOLD.
- Zero-wait memory: an N-byte instruction takes N cycles; out_valid rises the following cycle.
- HOLD: out_valid=1 and all bundle outputs stable until out_valid&out_ready.
- On transfer: pc=valP and state=FETCH_B0. If stat≠AOK, go to HALTED instead.
- stat=HLT for icode 0; HALTED issues no reads, out_valid=0, and is left only by pc_load.
- mem_err on any byte: abort remaining bytes, stat=ADR, go straight to HOLD. Bundle fields are undefined except stat.
- pc_load (highest priority after rst): next cycle pc=pc_in, state=FETCH_B0, out_valid=0, stat=AOK, byte_idx=0, valC=0, rA=rB=F.
  - In-flight read is dropped.
  - A coincident out_valid&out_ready is not a transfer.
- Address arithmetic is modulo 2^ADDR_W; pc+k wraps silently.
- rst mid-fetch: immediate return to reset values; no partial bundle ever presented.

Optional Feature:
FETCH_BRANCH_PREDICT_EN. When defined, on transfer of icode 7 (any ifun) or icode 8 with stat=AOK, pc=valC (predict taken); decode corrects mispredicts via pc_load. valP is still PC+9. When undefined, pc=valP for all instructions.

Test Plan:
- Zero-wait memory, pc=0, bytes 30 F4 FF FF FF FF FF FF FF FF, out_ready=1 -> 10 read cycles, then out_valid. Bundle: icode=3, ifun=0, rA=F, rB=4, valC=64'hFFFFFFFFFFFFFFFF, valP=10, stat=1. Next read at addr 10.
- Bytes 10 60 23 00 at pc=0, out_ready=1 -> nop bundle valP=1, then OPq icode=6 rA=2 rB=3 valP=3; 1+2 read cycles.
- Byte 00 -> bundle stat=2 valP=1. Then mem_rd_en stays 0 for 20 cycles. pc_load with pc_in=0x40 -> read at 0x40 next cycle.
- Byte C0 -> stat=4, HALTED. mem_err on byte 5 of an irmovq -> stat=3, HALTED.
- out_ready=0 for 5 cycles in HOLD -> outputs stable. pc_load during FETCH_C (k=3) with pc_in=0x100 -> out_valid never rises for the aborted instruction; next mem_addr=0x100.
- With FETCH_BRANCH_PREDICT_EN, bytes 70 + valC=0x200 -> after transfer mem_addr=0x200. Without the macro -> mem_addr=9.
